// File: rtl/pipeline_flush_unit_pkg.sv
// Shared hazard-control definitions: default counter width and the hazard cause
// classification reused by the hazard detection logic.
package pipeline_flush_unit_pkg;

   localparam int DEFAULT_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      HAZ_NONE     = 2'd0,
      HAZ_BJ_FLUSH = 2'd1,
      HAZ_LU_STALL = 2'd2
   } hazard_cause_e;

   // A resolved branch/jump always wins, because the stalled instruction is on the wrong path anyway
   function automatic hazard_cause_e hazardCause(input logic bjSig, input logic luHazSig);
      hazard_cause_e cause;
      cause = HAZ_NONE;
      if (bjSig) begin
         cause = HAZ_BJ_FLUSH;
      end else if (luHazSig) begin
         cause = HAZ_LU_STALL;
      end
      return cause;
   endfunction

endpackage

// File: rtl/pipeline_flush_unit_if.sv
// Hazard inputs, pipeline register/PC controls and debug event counters of the flush unit.
import pipeline_flush_unit_pkg::*;

interface pipeline_flush_unit_if #(
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
);

   logic                 bj_sig;
   logic                 lu_haz_sig;
   logic                 pr_if_id_reset;
   logic                 pr_if_id_hold;
   logic                 pr_id_ex_reset;
   logic                 pc_hold;
   logic [CNT_WIDTH-1:0] flush_cnt;
   logic [CNT_WIDTH-1:0] stall_cnt;

   modport master (
      output bj_sig, lu_haz_sig,
      input  pr_if_id_reset, pr_if_id_hold, pr_id_ex_reset, pc_hold, flush_cnt, stall_cnt
   );

   modport slave (
      input  bj_sig, lu_haz_sig,
      output pr_if_id_reset, pr_if_id_hold, pr_id_ex_reset, pc_hold, flush_cnt, stall_cnt
   );

endinterface

// File: rtl/pipeline_flush_unit_sat_counter.sv
// Event counter with enable and asynchronous active-low clear that sticks at all-ones
// instead of wrapping, so a long debug run never reports a misleadingly small count.
module pipeline_flush_unit_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;
   logic             w_atMax;

   assign w_atMax = &r_count;
   assign o_count = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_en && !w_atMax) begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_flush_unit.sv
// Turns branch/jump-taken and load-use hazard signals into flush/stall controls for the
// IF/ID, ID/EX registers and PC, and counts flush and stall cycles for debug readout.
import pipeline_flush_unit_pkg::*;

module pipeline_flush_unit #(
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   pipeline_flush_unit_if.slave bus
);

   hazard_cause_e w_cause;
   logic          w_flush;
   logic          w_stall;

   assign w_cause = hazardCause(bus.bj_sig, bus.lu_haz_sig);
   assign w_flush = (w_cause == HAZ_BJ_FLUSH);
   assign w_stall = (w_cause == HAZ_LU_STALL);

   // Controls are purely combinational and deliberately ignore reset
   assign bus.pr_if_id_reset = w_flush;
   assign bus.pr_if_id_hold  = w_stall;
   assign bus.pr_id_ex_reset = w_flush | w_stall;
   assign bus.pc_hold        = w_stall;

   pipeline_flush_unit_sat_counter #(.WIDTH(CNT_WIDTH)) u_flushCnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_flush),
      .o_count (bus.flush_cnt)
   );

   pipeline_flush_unit_sat_counter #(.WIDTH(CNT_WIDTH)) u_stallCnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (w_stall),
      .o_count (bus.stall_cnt)
   );

endmodule

// File: tb/tb_pipeline_flush_unit.sv
// Self-checking bench for pipeline_flush_unit: control truth table, counter scoreboard,
// saturation on a 2-bit instance, and asynchronous reset behaviour.
module tb_pipeline_flush_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   pipeline_flush_unit_if #(.CNT_WIDTH(32)) bus ();
   pipeline_flush_unit_if #(.CNT_WIDTH(2))  satBus ();

   pipeline_flush_unit #(.CNT_WIDTH(32)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   pipeline_flush_unit #(.CNT_WIDTH(2)) dutSat (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (satBus.slave)
   );

   typedef struct {
      logic bj;
      logic lu;
      logic ifIdReset;
      logic ifIdHold;
      logic idExReset;
      logic pcHold;
   } vector_t;

   typedef struct {
      logic [31:0] flush;
      logic [31:0] stall;
   } cntExp_t;

   vector_t     vectors[9];
   cntExp_t     sbQ[$];
   logic [31:0] expFlush = 0;
   logic [31:0] expStall = 0;
   logic [1:0]  expSat = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drive inputs mid-cycle and queue the counter values expected after the next edge
   task automatic applyStimulus(input logic bj, input logic lu);
      cntExp_t e;
      @(negedge clk);
      bus.bj_sig     = bj;
      bus.lu_haz_sig = lu;
      if (bj && expFlush != 32'hFFFF_FFFF) expFlush = expFlush + 1;
      if (lu && !bj && expStall != 32'hFFFF_FFFF) expStall = expStall + 1;
      e.flush = expFlush;
      e.stall = expStall;
      sbQ.push_back(e);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      cntExp_t e;
      @(posedge clk);
      #1;
      if (sbQ.size() == 0) begin
         checkOutput({tag, "_sbEmpty"}, 32'd1, 32'd0);
      end else begin
         e = sbQ.pop_front();
         checkOutput({tag, "_flushCnt"}, bus.flush_cnt, e.flush);
         checkOutput({tag, "_stallCnt"}, bus.stall_cnt, e.stall);
      end
   endtask

   task automatic checkControls(input string tag, input logic r, input logic h, input logic x, input logic p);
      checkOutput({tag, "_ifIdReset"}, {31'd0, bus.pr_if_id_reset}, {31'd0, r});
      checkOutput({tag, "_ifIdHold"},  {31'd0, bus.pr_if_id_hold},  {31'd0, h});
      checkOutput({tag, "_idExReset"}, {31'd0, bus.pr_id_ex_reset}, {31'd0, x});
      checkOutput({tag, "_pcHold"},    {31'd0, bus.pc_hold},        {31'd0, p});
   endtask

   initial begin
      vectors[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vectors[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vectors[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vectors[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      vectors[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vectors[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vectors[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vectors[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

      bus.bj_sig        = 1'b0;
      bus.lu_haz_sig    = 1'b0;
      satBus.bj_sig     = 1'b0;
      satBus.lu_haz_sig = 1'b0;

      #2;
      checkOutput("reset_flushCnt", bus.flush_cnt, 32'd0);
      checkOutput("reset_stallCnt", bus.stall_cnt, 32'd0);
      checkOutput("reset_satStallCnt", {30'd0, satBus.stall_cnt}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vectors[i].bj, vectors[i].lu);
         checkControls($sformatf("vec%0d", i), vectors[i].ifIdReset, vectors[i].ifIdHold,
                       vectors[i].idExReset, vectors[i].pcHold);
         checkCounters($sformatf("vec%0d", i));
      end

      // Saturation: 2-bit stall counter held in load-use for 5 edges
      bus.bj_sig     = 1'b0;
      bus.lu_haz_sig = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         satBus.lu_haz_sig = 1'b1;
         expSat = (expSat == 2'd3) ? 2'd3 : expSat + 2'd1;
         @(posedge clk);
         #1;
         checkOutput($sformatf("sat_edge%0d_stallCnt", i), {30'd0, satBus.stall_cnt}, {30'd0, expSat});
         checkOutput($sformatf("sat_edge%0d_flushCnt", i), {30'd0, satBus.flush_cnt}, 32'd0);
      end
      satBus.lu_haz_sig = 1'b0;

      // Asynchronous reset mid-count
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expFlush = 0;
      expStall = 0;
      checkOutput("preClear_flushCnt", bus.flush_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0);
         checkCounters($sformatf("bjRun%0d", i));
      end
      checkOutput("bjRun_flushIs3", bus.flush_cnt, 32'd3);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("asyncReset_flushCnt", bus.flush_cnt, 32'd0);
      checkOutput("asyncReset_satStallCnt", {30'd0, satBus.stall_cnt}, 32'd0);
      checkControls("duringReset_bj", 1'b1, 1'b0, 1'b1, 1'b0);
      bus.bj_sig     = 1'b0;
      bus.lu_haz_sig = 1'b1;
      #1;
      checkControls("duringReset_lu", 1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("heldReset_stallCnt", bus.stall_cnt, 32'd0);
      checkOutput("heldReset_flushCnt", bus.flush_cnt, 32'd0);
      rst_n = 1'b1;
      expFlush = 0;
      expStall = 0;
      applyStimulus(1'b1, 1'b0);
      checkCounters("afterReset");
      applyStimulus(1'b0, 1'b1);
      checkCounters("afterReset2");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/pipeline_flush_unit.md
Name: pipeline_flush_unit

Overview:
Combinational hazard-control block for the 5-stage RV32 pipeline core. It converts the branch/jump-taken signal (BJ_SIG) and the load-use hazard signal (LU_HAZ_SIG) into flush and stall controls for the IF/ID and ID/EX pipeline registers and the PC. It also keeps clocked, saturating performance counters of flush and stall events for debug readout.

Parameters:
CNT_WIDTH, 32, width of each event counter.

Ports:
CLK  input  1  core clock; rising edge.
RESET_N  input  1  asynchronous active-low reset; clears counters only.
BJ_SIG  input  1  branch taken or jump resolved in EX; younger instructions must be flushed.
LU_HAZ_SIG  input  1  load-use hazard detected in ID; one-cycle stall required.
PR_IF_ID_RESET  output  1  clear (bubble) the IF/ID register on the next edge.
PR_IF_ID_HOLD  output  1  hold the IF/ID register contents.
PR_ID_EX_RESET  output  1  clear (bubble) the ID/EX register on the next edge.
PC_HOLD  output  1  hold the PC (stall fetch).
FLUSH_CNT  output  CNT_WIDTH  number of cycles with BJ_SIG=1.
STALL_CNT  output  CNT_WIDTH  number of cycles with an effective load-use stall.

Behaviour:
- Control outputs are purely combinational, with zero latency and no dependence on CLK or RESET_N:
  - PR_IF_ID_RESET = BJ_SIG
  - PR_IF_ID_HOLD = LU_HAZ_SIG & ~BJ_SIG
  - PR_ID_EX_RESET = BJ_SIG | LU_HAZ_SIG
  - PC_HOLD = LU_HAZ_SIG & ~BJ_SIG
- Priority: BJ_SIG dominates. When both inputs are 1 (not expected in normal operation), the result is a flush: IF_ID_RESET=1, IF_ID_HOLD=0, ID_EX_RESET=1, PC_HOLD=0. Hold and reset of IF/ID are never asserted together.
- Both inputs 0: all control outputs 0.
- Outputs are fully defined (no X/Z) whenever the inputs are 0/1.
- Counters:
  - RESET_N=0 asynchronously forces FLUSH_CNT=0 and STALL_CNT=0.
  - On each CLK rising edge with RESET_N=1:
    - FLUSH_CNT increments if BJ_SIG=1.
    - STALL_CNT increments if LU_HAZ_SIG=1 and BJ_SIG=0.
  - Both counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - Reset asserted mid-count clears the counters immediately. Counting resumes on the first rising edge after RESET_N deasserts.
- Reset has no effect on the combinational control outputs.

Decomposition:
- Shared core package: a localparam for the default counter width. Optionally an enum of hazard causes (NONE, BJ_FLUSH, LU_STALL), reused by the hazard detection unit.
- One natural sub-module: sat_counter (parameterised width, enable, async active-low clear, saturating increment), instantiated twice. Control logic stays in the top module.

Test Plan:
- Normal: BJ=0, LU=0 -> IF_ID_RESET=0, IF_ID_HOLD=0, ID_EX_RESET=0, PC_HOLD=0.
- Branch/jump: BJ=1, LU=0 -> IF_ID_RESET=1, IF_ID_HOLD=0, ID_EX_RESET=1, PC_HOLD=0; FLUSH_CNT increments by 1 per clock edge.
- Load-use: BJ=0, LU=1 -> IF_ID_RESET=0, IF_ID_HOLD=1, ID_EX_RESET=1, PC_HOLD=1; STALL_CNT increments per edge.
- Simultaneous: BJ=1, LU=1 -> IF_ID_RESET=1, IF_ID_HOLD=0, ID_EX_RESET=1, PC_HOLD=0; only FLUSH_CNT increments.
- Reset: 3 BJ cycles (FLUSH_CNT=3), then RESET_N=0 mid-cycle -> FLUSH_CNT=0 with no clock edge; control outputs still follow the inputs during reset.
- Saturation: CNT_WIDTH=2, hold LU=1 for 5 edges -> STALL_CNT=3 after the third edge and stays at 3.
